// File: rtl/mau_pkg.sv
// Shared encodings, FSM state type and byte-enable helper for the load/store stage.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IO_WAIT = 2'd1,
    IO_DONE = 2'd2
  } mau_state_t;

  // Enables for the low 32-bit word; word accesses are widened to all ones by the caller.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    be_gen = 4'b0001 << lane;
      SZ_H:    be_gen = 4'b0011 << lane;
      SZ_W:    be_gen = 4'b1111;
      default: be_gen = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane alignment: load extract with sign/zero extension and store lane shift.
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_size,
  input  logic [1:0]      i_lane,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_raw,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic [XLEN-1:0] o_wdata
);

  logic [4:0]      w_sh;
  logic [XLEN-1:0] w_shr;

  assign w_sh  = {i_lane, 3'b000};
  assign w_shr = i_raw >> w_sh;

  always_comb begin
    o_rdata = i_raw;
    o_wdata = i_wdata;
    case (i_size)
      SZ_B: begin
        o_rdata = {{(XLEN-8){~i_unsigned & w_shr[7]}}, w_shr[7:0]};
        o_wdata = XLEN'(i_wdata[7:0]) << w_sh;
      end
      SZ_H: begin
        o_rdata = {{(XLEN-16){~i_unsigned & w_shr[15]}}, w_shr[15:0]};
        o_wdata = XLEN'(i_wdata[15:0]) << w_sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: byte-enabled DMEM, stalling IO request/ack path with timeout,
// misalignment abort and a combinational debug read port.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DMEM_AW    = 8,
  parameter int IO_SEL_BIT = 10,
  parameter int IO_AW      = 8,
  parameter int IO_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [1:0]        i_mem_size,
  input  logic              i_mem_unsigned,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_stall,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_io_req,
  output logic              o_io_we,
  output logic [IO_AW-1:0]  o_io_addr,
  output logic [XLEN-1:0]   o_io_wdata,
  output logic [XLEN/8-1:0] o_io_be,
  input  logic [XLEN-1:0]   i_io_din,
  input  logic              i_io_ack,
  input  logic [DMEM_AW-1:0] i_dbg_addr,
  output logic [XLEN-1:0]   o_dbg_data,
  output logic [1:0]        o_dbg_state
);

  localparam int CW = $clog2(IO_TIMEOUT) + 1;

  // IO handshake: io_req rises the edge after an IO request is accepted and stays
  // high, with io_addr/io_we/io_be/io_wdata held, until the edge where io_ack is
  // seen or the wait budget runs out; io_ack outside IO_WAIT is ignored.
  mau_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_err;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [XLEN-1:0]   r_data;
  logic              r_io_req;
  logic              r_io_we;
  logic [IO_AW-1:0]  r_io_addr;
  logic [XLEN-1:0]   r_io_wdata;
  logic [XLEN/8-1:0] r_io_be;
  logic [XLEN-1:0]   r_mem [0:(1<<DMEM_AW)-1];

  logic              w_io_sel;
  logic [1:0]        w_lane;
  logic [DMEM_AW-1:0] w_idx;
  logic              w_mis_cond;
  logic              w_io_start;
  logic              w_dmem_we;
  logic [XLEN/8-1:0] w_be;
  logic [XLEN-1:0]   w_dmem_raw;
  logic [XLEN-1:0]   w_dmem_rdata;
  logic [XLEN-1:0]   w_dmem_wsh;
  logic [1:0]        w_io_al_size;
  logic [1:0]        w_io_al_lane;
  logic              w_io_al_uns;
  logic [XLEN-1:0]   w_io_rdata;
  logic [XLEN-1:0]   w_io_wsh;
  logic              w_unused;

  assign w_io_sel   = i_addr[IO_SEL_BIT];
  assign w_lane     = i_addr[1:0];
  assign w_idx      = i_addr[DMEM_AW+1:2];
  assign w_unused   = ^i_addr;
  assign w_mis_cond = (i_mem_size == SZ_H && i_addr[0]) ||
                      (i_mem_size == SZ_W && i_addr[1:0] != 2'b00) ||
                      (i_mem_size == 2'b11);
  assign w_io_start = (r_state == IDLE) && i_mem_req && w_io_sel && !w_mis_cond;
  assign w_dmem_we  = i_mem_req && i_mem_we && !w_io_sel && !w_mis_cond;
  assign w_dmem_raw = r_mem[w_idx];

  always_comb begin
    w_be      = '0;
    w_be[3:0] = be_gen(i_mem_size, w_lane);
    if (i_mem_size == SZ_W) w_be = '1;
  end

  // The IO aligner sees the live request in IDLE so its store shift can be latched,
  // and the latched access fields afterwards to extract the captured read data.
  assign w_io_al_size = (r_state == IDLE) ? i_mem_size     : r_size;
  assign w_io_al_lane = (r_state == IDLE) ? w_lane         : r_lane;
  assign w_io_al_uns  = (r_state == IDLE) ? i_mem_unsigned : r_uns;

  mau_lane_align #(.XLEN(XLEN)) u_dmem_align (
    .i_size(i_mem_size), .i_lane(w_lane), .i_unsigned(i_mem_unsigned),
    .i_raw(w_dmem_raw), .i_wdata(i_wdata),
    .o_rdata(w_dmem_rdata), .o_wdata(w_dmem_wsh)
  );

  mau_lane_align #(.XLEN(XLEN)) u_io_align (
    .i_size(w_io_al_size), .i_lane(w_io_al_lane), .i_unsigned(w_io_al_uns),
    .i_raw(r_data), .i_wdata(i_wdata),
    .o_rdata(w_io_rdata), .o_wdata(w_io_wsh)
  );

  always_ff @(posedge clk) begin
    for (int b = 0; b < XLEN/8; b++) begin
      if (w_dmem_we && w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_dmem_wsh[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_lane     <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_data     <= '0;
      r_io_req   <= 1'b0;
      r_io_we    <= 1'b0;
      r_io_addr  <= '0;
      r_io_wdata <= '0;
      r_io_be    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_io_start) begin
            r_state    <= IO_WAIT;
            r_io_req   <= 1'b1;
            r_io_we    <= i_mem_we;
            r_io_addr  <= i_addr[IO_AW+1:2];
            r_io_wdata <= w_io_wsh;
            r_io_be    <= w_be;
            r_lane     <= w_lane;
            r_size     <= i_mem_size;
            r_uns      <= i_mem_unsigned;
            r_cnt      <= '0;
            r_err      <= 1'b0;
          end
        end
        IO_WAIT: begin
          if (i_io_ack) begin
            r_data   <= i_io_din;
            r_err    <= 1'b0;
            r_io_req <= 1'b0;
            r_state  <= IO_DONE;
          end else if (r_cnt == CW'(IO_TIMEOUT - 1)) begin
            r_data   <= '0;
            r_err    <= 1'b1;
            r_io_req <= 1'b0;
            r_state  <= IO_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IO_DONE: begin
          r_io_we <= 1'b0;
          r_io_be <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    if (r_state == IO_DONE)
      o_rdata = w_io_rdata;
    else if (r_state == IDLE && i_mem_req && !i_mem_we && !w_io_sel && !w_mis_cond)
      o_rdata = w_dmem_rdata;
  end

  assign o_stall     = w_io_start || (r_state == IO_WAIT);
  assign o_misalign  = i_mem_req && w_mis_cond;
  assign o_bus_err   = (r_state == IO_DONE) && r_err;
  assign o_io_req    = r_io_req;
  assign o_io_we     = r_io_we;
  assign o_io_addr   = r_io_addr;
  assign o_io_wdata  = r_io_wdata;
  assign o_io_be     = r_io_be;
  assign o_dbg_data  = r_mem[i_dbg_addr];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected responses are queued by the drivers
// and popped by a monitor whenever an access completes (mem_req high, stall low).
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_req, i_mem_we, i_mem_unsigned;
  logic [1:0]  i_mem_size;
  logic [31:0] i_addr, i_wdata;
  logic [31:0] o_rdata;
  logic        o_stall, o_misalign, o_bus_err;
  logic        o_io_req, o_io_we;
  logic [7:0]  o_io_addr;
  logic [31:0] o_io_wdata;
  logic [3:0]  o_io_be;
  logic [31:0] i_io_din;
  logic        i_io_ack;
  logic [7:0]  i_dbg_addr;
  logic [31:0] o_dbg_data;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  // {check_rdata, misalign, bus_err, rdata}
  logic [34:0] exp_q[$];
  logic [34:0] mon_e;

  mem_access_unit #(.XLEN(32), .DMEM_AW(8), .IO_SEL_BIT(10), .IO_AW(8), .IO_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_size(i_mem_size),
    .i_mem_unsigned(i_mem_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_stall(o_stall), .o_misalign(o_misalign), .o_bus_err(o_bus_err),
    .o_io_req(o_io_req), .o_io_we(o_io_we), .o_io_addr(o_io_addr),
    .o_io_wdata(o_io_wdata), .o_io_be(o_io_be), .i_io_din(i_io_din), .i_io_ack(i_io_ack),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && i_mem_req && !o_stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_completion: addr 0x%08h, nothing expected", i_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_misalign", {31'b0, o_misalign}, {31'b0, mon_e[33]});
        check("resp_bus_err", {31'b0, o_bus_err}, {31'b0, mon_e[32]});
        if (mon_e[34]) check("resp_rdata", o_rdata, mon_e[31:0]);
      end
    end
  end

  // drivers
  task automatic dmem_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_mis, input logic [31:0] exp_rd);
    exp_q.push_back({(~we | exp_mis), exp_mis, 1'b0, exp_rd});
    @(posedge clk); #1;
    i_mem_req = 1'b1; i_mem_we = we; i_mem_size = size; i_mem_unsigned = uns;
    i_addr = addr; i_wdata = wdata;
    @(negedge clk);
    check("dmem_no_stall", {31'b0, o_stall}, 32'd0);
    check("dmem_no_io_req", {31'b0, o_io_req}, 32'd0);
    @(posedge clk); #1;
    i_mem_req = 1'b0;
  endtask

  task automatic io_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int ack_at, input logic [31:0] din,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input int exp_stall, input int exp_req,
                       input logic [7:0] exp_ioaddr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] wd_mask);
    int  n_stall = 0;
    int  n_req   = 0;
    int  k       = 0;
    bit  done    = 0;
    bit  seen    = 0;
    exp_q.push_back({~we, 1'b0, exp_err, exp_rd});
    @(posedge clk); #1;
    i_mem_req = 1'b1; i_mem_we = we; i_mem_size = size; i_mem_unsigned = uns;
    i_addr = addr; i_wdata = wdata; i_io_ack = 1'b0; i_io_din = din;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (o_stall) n_stall++;
      if (o_io_req) begin
        n_req++;
        if (!seen) begin
          seen = 1;
          check("io_addr", {24'b0, o_io_addr}, {24'b0, exp_ioaddr});
          check("io_be", {28'b0, o_io_be}, {28'b0, exp_be});
          check("io_we", {31'b0, o_io_we}, {31'b0, we});
          if (wd_mask != 0) check("io_wdata", o_io_wdata & wd_mask, exp_wd & wd_mask);
        end
      end
      if (!o_stall) done = 1;
      else begin
        @(posedge clk); #1;
        if (o_io_req) begin
          k++;
          i_io_ack = (k == ack_at);
        end else begin
          i_io_ack = 1'b0;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL io_complete_timeout: stall never dropped after %0d cycles", n_stall);
    end
    check("io_stall_cycles", n_stall, exp_stall);
    check("io_req_cycles", n_req, exp_req);
    @(posedge clk); #1;
    i_mem_req = 1'b0; i_io_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_size = SZ_W; i_mem_unsigned = 1'b0;
    i_addr = '0; i_wdata = '0; i_io_din = '0; i_io_ack = 1'b0; i_dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", {30'b0, o_dbg_state}, 32'(IDLE));
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_stall", {31'b0, o_stall}, 32'd0);
    check("rst_misalign", {31'b0, o_misalign}, 32'd0);
    check("rst_bus_err", {31'b0, o_bus_err}, 32'd0);
    check("rst_io_req", {31'b0, o_io_req}, 32'd0);
    check("rst_io_be", {28'b0, o_io_be}, 32'd0);

    // DMEM word store then sub-word loads
    dmem_op(1, SZ_W, 0, 32'h010, 32'hDEADBEEF, 0, 32'h0);
    dmem_op(0, SZ_B, 0, 32'h011, 32'h0, 0, 32'hFFFFFFBE);
    dmem_op(0, SZ_H, 1, 32'h012, 32'h0, 0, 32'h0000DEAD);
    i_dbg_addr = 8'd4;
    #1 check("dbg_word4", o_dbg_data, 32'hDEADBEEF);

    // byte store into the top lane
    dmem_op(1, SZ_B, 0, 32'h013, 32'h0000005A, 0, 32'h0);
    #1 check("dbg_after_sb", o_dbg_data, 32'h5AADBEEF);
    dmem_op(0, SZ_B, 1, 32'h013, 32'h0, 0, 32'h0000005A);
    dmem_op(0, SZ_H, 0, 32'h010, 32'h0, 0, 32'hFFFFBEEF);
    dmem_op(0, SZ_W, 0, 32'h010, 32'h0, 0, 32'h5AADBEEF);

    // IO word load, ack in third wait cycle
    io_op(0, SZ_W, 0, 32'h404, 32'h0, 3, 32'h12345678, 0, 32'h12345678,
          4, 3, 8'd1, 4'b1111, 32'h0, 32'h0);
    // IO half store with no ack: timeout
    io_op(1, SZ_H, 0, 32'h406, 32'h0000BEEF, 0, 32'h0, 1, 32'h0,
          17, 16, 8'd1, 4'b1100, 32'hBEEF0000, 32'hFFFF0000);
    #1 check("idle_after_timeout", {30'b0, o_dbg_state}, 32'(IDLE));
    // IO signed half load, ack in the first wait cycle
    io_op(0, SZ_H, 0, 32'h406, 32'h0, 1, 32'h80010000, 0, 32'hFFFF8001,
          2, 1, 8'd1, 4'b1100, 32'h0, 32'h0);

    // misaligned accesses
    dmem_op(0, SZ_W, 0, 32'h402, 32'h0, 1, 32'h0);
    dmem_op(0, SZ_H, 0, 32'h011, 32'h0, 1, 32'h0);
    dmem_op(1, SZ_H, 0, 32'h011, 32'h0000FFFF, 1, 32'h0);
    dmem_op(0, 2'b11, 0, 32'h010, 32'h0, 1, 32'h0);
    #1 check("dbg_after_misalign", o_dbg_data, 32'h5AADBEEF);

    // reset during the second IO_WAIT cycle
    @(posedge clk); #1;
    i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_size = SZ_W; i_addr = 32'h404; i_io_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_io_req", {31'b0, o_io_req}, 32'd1);
    rst = 1'b1; i_mem_req = 1'b0;
    #1;
    check("midrst_io_req", {31'b0, o_io_req}, 32'd0);
    check("midrst_stall", {31'b0, o_stall}, 32'd0);
    check("midrst_state", {30'b0, o_dbg_state}, 32'(IDLE));
    check("midrst_bus_err", {31'b0, o_bus_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    dmem_op(0, SZ_W, 0, 32'h010, 32'h0, 0, 32'h5AADBEEF);

    repeat (2) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store stage for the CPU datapath. It sits between the ALU result and register writeback.
- Owns the data memory, a memory-mapped IO region and a debug read port.
- Adds three things the previous stage lacked: byte, halfword and word accesses with sign or zero extension; a stalling request/acknowledge handshake to IO with a timeout; and misalignment detection.

Parameters:
- XLEN, 32, datapath width (power of two, ≥32)
- DMEM_AW, 8, data memory word-address width (depth = 2**DMEM_AW words)
- IO_SEL_BIT, 10, address bit that selects IO (1) versus DMEM (0)
- IO_AW, 8, IO word-address width
- IO_TIMEOUT, 16, maximum cycles spent in IO_WAIT before a bus error

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  in  1  access valid this cycle; must stay stable while stall=1
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- mem_unsigned  in  1  zero-extend loads when 1
- addr  in  XLEN  byte address (ALU result)
- wdata  in  XLEN  store data, right-aligned
- rdata  out  XLEN  aligned, extended load data
- stall  out  1  holds the CPU
- misalign  out  1  access aborted because of alignment or illegal size
- bus_err  out  1  IO timeout
- io_req  out  1  IO transaction request
- io_we  out  1  IO store
- io_addr  out  IO_AW  addr[IO_AW+1:2]
- io_wdata  out  XLEN  lane-shifted store data
- io_be  out  XLEN/8  byte enables
- io_din  in  XLEN  IO read data
- io_ack  in  1  IO completes this cycle
- dbg_addr  in  DMEM_AW  debug word address
- dbg_data  out  XLEN  DMEM[dbg_addr], combinational

Behaviour:
- Address decode: io_sel = addr[IO_SEL_BIT]. DMEM index = addr[DMEM_AW+1:2]. Lane = addr[1:0].
- Misalignment:
  - Conditions: half with addr[0]=1; word with addr[1:0]≠0; mem_size=11.
  - Response: misalign=mem_req&cond, combinational. No write, no IO transaction, rdata=0, stall=0.
- Byte enables:
  - byte: 1<<lane
  - half: 3<<lane
  - word: all ones
  - Write data is replicated or shifted into the addressed lane.
- DMEM:
  - Store: bytes with enable set are written at the rising edge when mem_req&mem_we&~io_sel&~misalign.
  - Load: combinational read; rdata is valid in the same cycle; stall=0.
  - Contents are not reset.
- Load extract: shift right by lane×8, mask to size, then sign-extend from bit 7 or bit 15 unless mem_unsigned. Word loads pass through unchanged.
- FSM, states IDLE, IO_WAIT, IO_DONE:
  - IDLE: if mem_req&io_sel&~misalign, then stall=1 and go to IO_WAIT. Latch the lane, size, unsigned flag, io_addr, io_wdata, io_be and io_we into registers. Clear the timeout counter.
  - IO_WAIT: io_req=1 (registered), stall=1.
    - io_ack=1: capture io_din, go to IO_DONE.
    - Otherwise the counter increments. When it reaches IO_TIMEOUT-1, go to IO_DONE with err_flag=1 and captured data=0.
    - io_ack on the same edge as expiry: the ack wins and err_flag=0.
  - IO_DONE: stall=0, io_req=0, rdata=extract(captured data), bus_err=err_flag. Next edge goes to IDLE unconditionally.
- IO timing: minimum 2 stall cycles (ack in the first IO_WAIT cycle); maximum IO_TIMEOUT+1.
- io_ack while not in IO_WAIT is ignored.
- IO registered outputs are held for the whole of IO_WAIT.
- Reset (asynchronous, any state):
  - state=IDLE; io_req, io_we, io_be, bus_err, counter and err_flag all 0.
  - An in-flight IO transaction is abandoned; io_req falls immediately.
- Outputs when mem_req=0 in IDLE: rdata=0, stall=0, misalign=0, bus_err=0.

Decomposition:
- Shared package mau_pkg:
  - Size encodings SZ_B, SZ_H, SZ_W.
  - Enum mau_state_t {IDLE, IO_WAIT, IO_DONE}.
  - Function be_gen(size, lane).
- One sub-module, mau_lane_align: purely combinational load extract/extend and store shift. It is instantiated twice: for the DMEM path and for the IO capture path.

Test Plan:
- Store word 0xDEADBEEF to 0x010, then load byte 0x011 signed → rdata 0xFFFFFFBE; load half unsigned 0x012 → 0x0000DEAD; stall stays 0; dbg_addr=4 → dbg_data 0xDEADBEEF.
- Store byte 0x5A to 0x013 over 0xDEADBEEF → word at 0x010 becomes 0x5AADBEEF; load byte unsigned 0x013 → 0x0000005A.
- Load word from 0x404 with io_ack raised in the 3rd IO_WAIT cycle and io_din=0x12345678 → io_addr=1, 4 stall cycles, then rdata 0x12345678 for one cycle with bus_err=0.
- IO store half 0xBEEF to 0x406 with no ack, IO_TIMEOUT=16 → io_req high 16 cycles, io_be=1100, io_wdata[31:16]=0xBEEF, then bus_err=1 for one cycle, then IDLE.
- Load word at 0x402 and half at 0x011 → misalign=1, stall=0, no io_req, DMEM unchanged.
- Assert rst during the 2nd IO_WAIT cycle → io_req and stall drop at once, state=IDLE, bus_err=0; a following DMEM load returns correct data.
